// File: rtl/divider_controller_if.sv
// Configuration, run-control and status bundle for divider_controller.
// The master side offers configuration and run commands; the slave is the divider.
interface divider_controller_if #(
  parameter int CW = 32
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_period;
  logic [15:0]   cfg_count;
  logic          start;
  logic          stop;
  logic          out;
  logic          tick;
  logic          busy;
  logic          done;

  modport master (
    output cfg_valid, cfg_period, cfg_count, start, stop,
    input  cfg_ready, out, tick, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_period, cfg_count, start, stop,
    output cfg_ready, out, tick, busy, done
  );
endinterface

// File: rtl/divider_controller.sv
// Programmable clock divider: toggles out every period+1 cycles, for a fixed
// number of toggles or continuously, with a one-cycle done pulse on completion.
module divider_controller #(
  parameter int          CW         = 32,
  parameter int unsigned DEF_PERIOD = 50000000
) (
  input logic              clk,
  input logic              reset,
  divider_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] period_q;
  logic [15:0]   count_q;
  logic [CW-1:0] intCount_q;
  logic [15:0]   remaining_q;
  logic          out_q;
  logic          tick_q;
  logic          done_q;

  // A zero period would make every cycle terminal, so it is promoted to 1.
  logic [CW-1:0] period_d;
  logic [15:0]   remaining_d;

  assign period_d    = (bus.cfg_period == '0) ? CW'(1) : bus.cfg_period;
  assign remaining_d = bus.cfg_valid ? bus.cfg_count : count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      period_q    <= CW'(DEF_PERIOD);
      count_q     <= '0;
      intCount_q  <= '0;
      remaining_q <= '0;
      out_q       <= 1'b0;
      tick_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.cfg_valid) begin
            period_q <= period_d;
            count_q  <= bus.cfg_count;
          end
          if (bus.start) begin
            state_q     <= RUN;
            intCount_q  <= '0;
            out_q       <= 1'b0;
            remaining_q <= remaining_d;
          end
        end
        RUN: begin
          // Stop takes priority over a coincident terminal cycle.
          if (bus.stop) begin
            state_q    <= IDLE;
            intCount_q <= '0;
          end else if (intCount_q == period_q) begin
            intCount_q <= '0;
            out_q      <= ~out_q;
            tick_q     <= 1'b1;
            if (count_q != '0) begin
              remaining_q <= remaining_q - 16'd1;
              if (remaining_q == 16'd1) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end
            end
          end else begin
            intCount_q <= intCount_q + CW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.cfg_ready = (state_q == IDLE);
  assign bus.busy      = (state_q == RUN);
  assign bus.out       = out_q;
  assign bus.tick      = tick_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_divider_controller.sv
// Self-checking bench for divider_controller: directed scenarios with literal
// expectations followed by randomized traffic compared against a behavioural model.
module tb_divider_controller;

  localparam int CW  = 32;
  localparam int DEF = 7;

  logic clk;
  logic reset;

  divider_controller_if #(.CW(CW)) dif ();

  divider_controller #(
    .CW         (CW),
    .DEF_PERIOD (DEF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif)
  );

  int checks = 0;
  int errors = 0;
  int tickCount = 0;
  int doneCount = 0;

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: a run is measured as elapsed cycles since start, and a
  // toggle happens whenever that count is a multiple of period+1.
  int     mMode    = 0;
  longint mPeriod  = DEF;
  longint mCount   = 0;
  longint mElapsed = 0;
  longint mToggles = 0;
  bit     mOut     = 1'b0;
  bit     mTick    = 1'b0;
  bit     mDone    = 1'b0;

  task automatic modelReset();
    mMode    = 0;
    mPeriod  = DEF;
    mCount   = 0;
    mElapsed = 0;
    mToggles = 0;
    mOut     = 1'b0;
    mTick    = 1'b0;
    mDone    = 1'b0;
  endtask

  task automatic modelStep();
    mTick = 1'b0;
    mDone = 1'b0;
    case (mMode)
      0: begin
        if (dif.cfg_valid) begin
          mPeriod = (dif.cfg_period == 0) ? 1 : longint'(dif.cfg_period);
          mCount  = longint'(dif.cfg_count);
        end
        if (dif.start) begin
          mMode    = 1;
          mElapsed = 0;
          mToggles = 0;
          mOut     = 1'b0;
        end
      end
      1: begin
        if (dif.stop) begin
          mMode = 0;
        end else begin
          mElapsed++;
          if (mElapsed % (mPeriod + 1) == 0) begin
            mOut  = !mOut;
            mTick = 1'b1;
            mToggles++;
            if (mCount != 0 && mToggles == mCount) begin
              mMode = 2;
              mDone = 1'b1;
            end
          end
        end
      end
      default: mMode = 0;
    endcase
  endtask

  // The model advances on the same edges as the design, including async reset.
  always @(posedge clk or posedge reset) begin
    if (reset) modelReset();
    else       modelStep();
  end

  // Every cycle, away from the active edge, compare all outputs with the model.
  always @(negedge clk) begin
    checkOutput("out",       dif.out,       mOut);
    checkOutput("tick",      dif.tick,      mTick);
    checkOutput("done",      dif.done,      mDone);
    checkOutput("busy",      dif.busy,      (mMode == 1));
    checkOutput("cfg_ready", dif.cfg_ready, (mMode == 0));
  end

  // Event counters used by the directed scenarios' literal expectations.
  always @(negedge clk) begin
    if (dif.tick) tickCount++;
    if (dif.done) doneCount++;
  end

  task automatic clearCounts();
    tickCount = 0;
    doneCount = 0;
  endtask

  task automatic runCycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit v, input int p, input int c, input bit s, input bit sp);
    dif.cfg_valid  = v;
    dif.cfg_period = CW'(p);
    dif.cfg_count  = 16'(c);
    dif.start      = s;
    dif.stop       = sp;
  endtask

  task automatic configure(input int p, input int c);
    applyStimulus(1'b1, p, c, 1'b0, 1'b0);
    runCycles(1);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic startPulse();
    dif.start = 1'b1;
    runCycles(1);
    dif.start = 1'b0;
  endtask

  task automatic stopPulse();
    dif.stop = 1'b1;
    runCycles(1);
    dif.stop = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
    runCycles(2);
    checkOutput("rst_ready", dif.cfg_ready, 1);
    checkOutput("rst_out",   dif.out,       0);
    checkOutput("rst_busy",  dif.busy,      0);
    reset = 1'b0;
    runCycles(1);

    // Default period of 7 after reset, continuous: toggles every 8 cycles.
    clearCounts();
    startPulse();
    runCycles(24);
    checkOutput("def_ticks", tickCount, 3);
    checkOutput("def_out",   dif.out,   1);
    checkOutput("def_busy",  dif.busy,  1);
    stopPulse();
    checkOutput("def_stop_busy", dif.busy, 0);
    checkOutput("def_stop_out",  dif.out,  1);

    // Period 3, four toggles, then a single done cycle.
    configure(3, 4);
    clearCounts();
    startPulse();
    runCycles(18);
    checkOutput("cnt_ticks", tickCount,     4);
    checkOutput("cnt_dones", doneCount,     1);
    checkOutput("cnt_out",   dif.out,       0);
    checkOutput("cnt_ready", dif.cfg_ready, 1);

    // Zero period stored as 1, zero count runs forever.
    configure(0, 0);
    clearCounts();
    startPulse();
    runCycles(19);
    checkOutput("p0_ticks", tickCount, 9);
    checkOutput("p0_dones", doneCount, 0);
    checkOutput("p0_busy",  dif.busy,  1);
    stopPulse();

    // Stop on the terminal cycle of the second interval beats the toggle.
    configure(5, 2);
    clearCounts();
    startPulse();
    runCycles(11);
    stopPulse();
    checkOutput("stp_ticks", tickCount, 1);
    checkOutput("stp_out",   dif.out,   1);
    checkOutput("stp_busy",  dif.busy,  0);
    runCycles(10);
    checkOutput("stp_dones", doneCount, 0);
    checkOutput("stp_after", tickCount, 1);

    // Configuration and start together; later config during RUN is ignored.
    clearCounts();
    applyStimulus(1'b1, 2, 0, 1'b1, 1'b0);
    runCycles(1);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
    runCycles(2);
    checkOutput("cs_early", tickCount, 0);
    runCycles(1);
    checkOutput("cs_first", tickCount, 1);
    applyStimulus(1'b1, 6, 1, 1'b0, 1'b0);
    runCycles(1);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
    runCycles(5);
    checkOutput("cs_run_cfg", tickCount, 3);
    stopPulse();

    // Asynchronous reset mid-run with out high, then default period is back.
    configure(1, 0);
    clearCounts();
    startPulse();
    runCycles(2);
    checkOutput("ar_pre_out", dif.out, 1);
    reset = 1'b1;
    #1;
    checkOutput("ar_out",   dif.out,       0);
    checkOutput("ar_busy",  dif.busy,      0);
    checkOutput("ar_ready", dif.cfg_ready, 1);
    runCycles(1);
    reset = 1'b0;
    clearCounts();
    startPulse();
    runCycles(7);
    checkOutput("ar_def_early", tickCount, 0);
    runCycles(1);
    checkOutput("ar_def_tick",  tickCount, 1);
    stopPulse();

    // Randomized traffic, including occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 9) < 3), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 4)), ($urandom_range(0, 9) < 2),
                    ($urandom_range(0, 39) == 0));
      if ($urandom_range(0, 299) == 0) reset = 1'b1;
      runCycles(1);
      reset = 1'b0;
    end
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
    runCycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
